// File: rtl/msrv_32_wb_pkg.sv
// ---------------------------------------------------------------------------
// msrv_32_wb_pkg
// Shared definitions for the MSRV32 stage-3 (writeback) controller:
//   - writeback mux select encodings (wb_sel_e)
//   - writeback controller state encoding (wb_state_e)
//   - default load timeout and timeout counter width
// ---------------------------------------------------------------------------
package msrv_32_wb_pkg;

  typedef enum logic [2:0] {
    WB_ALU     = 3'b000,
    WB_LU      = 3'b001,
    WB_IMM     = 3'b010,
    WB_IADDER  = 3'b011,
    WB_CSR     = 3'b100,
    WB_PC_PLUS = 3'b101
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB        = 2'd1,
    LOAD_WAIT = 2'd2,
    FAULT     = 2'd3
  } wb_state_e;

  localparam int unsigned DEFAULT_LOAD_TIMEOUT = 15;
  localparam int unsigned DEFAULT_TO_W         = 8;

endpackage

// File: rtl/msrv_32_wb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// msrv_32_wb_timeout_ctr
// Saturating cycle counter used to bound the time spent waiting for a
// data-memory response.
// Ports:
//   clk_i      core clock
//   rst_n_i    asynchronous active-low reset
//   clr_i      synchronous clear (wins over enable)
//   en_i       count one cycle
//   expired_o  high while the count equals LOAD_TIMEOUT-1
// ---------------------------------------------------------------------------
module msrv_32_wb_timeout_ctr
  import msrv_32_wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = DEFAULT_LOAD_TIMEOUT,
  parameter int unsigned TO_W         = DEFAULT_TO_W
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(LOAD_TIMEOUT - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      // Saturate at all-ones so a held enable can never wrap back to 0.
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST_CNT);

endmodule

// File: rtl/msrv_32_wb_ctrl_unit.sv
// ---------------------------------------------------------------------------
// msrv_32_wb_ctrl_unit
// Stage-3 (writeback) controller for the MSRV32 core. Captures the decoded
// writeback controls from stage 2, drives the writeback mux select and the
// register-file / CSR write strobes, holds the pipeline while a load waits
// for its data-memory response (with timeout), and kills writeback on flush.
// Ports:
//   ms_riscv32_mp_clk_in    core clock
//   ms_riscv32_mp_rst_n_in  asynchronous active-low reset
//   valid_in                stage-2 instruction valid
//   wb_mux_sel_in[2:0]      writeback select from decode
//   rd_addr_in[4:0]         destination register
//   rf_wr_en_in             instruction writes the register file
//   csr_wr_en_in            instruction writes a CSR
//   is_load_in              instruction is a load
//   dmem_ack_in             load data valid this cycle
//   flush_in                trap/redirect, kills stage 3
//   wb_mux_sel_reg_out[2:0] registered writeback select
//   rd_addr_reg_out[4:0]    registered destination register
//   rf_wr_en_out            register-file write strobe
//   csr_wr_en_out           CSR write strobe
//   stall_out               hold stages 1-2
//   load_fault_out          one-cycle load timeout pulse
// ---------------------------------------------------------------------------
module msrv_32_wb_ctrl_unit
  import msrv_32_wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = DEFAULT_LOAD_TIMEOUT,
  parameter int unsigned TO_W         = DEFAULT_TO_W
) (
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_n_in,
  input  logic       valid_in,
  input  logic [2:0] wb_mux_sel_in,
  input  logic [4:0] rd_addr_in,
  input  logic       rf_wr_en_in,
  input  logic       csr_wr_en_in,
  input  logic       is_load_in,
  input  logic       dmem_ack_in,
  input  logic       flush_in,
  output logic [2:0] wb_mux_sel_reg_out,
  output logic [4:0] rd_addr_reg_out,
  output logic       rf_wr_en_out,
  output logic       csr_wr_en_out,
  output logic       stall_out,
  output logic       load_fault_out
);

  wb_state_e   state_q, state_d;
  logic [2:0]  sel_q;
  logic [4:0]  rd_q;
  logic        rf_en_q;
  logic        csr_en_q;
  logic        accept;
  logic        expired;
  logic        rd_nonzero;

  assign rd_nonzero = (rd_q != 5'd0);

  // Counter is held at zero outside LOAD_WAIT, so it always starts from 0 on
  // entry; a flush clears it immediately.
  msrv_32_wb_timeout_ctr #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout_ctr (
    .clk_i    (ms_riscv32_mp_clk_in),
    .rst_n_i  (ms_riscv32_mp_rst_n_in),
    .clr_i    ((state_q != LOAD_WAIT) || flush_in),
    .en_i     (state_q == LOAD_WAIT),
    .expired_o(expired)
  );

  always_comb begin
    state_d        = state_q;
    stall_out      = 1'b0;
    rf_wr_en_out   = 1'b0;
    csr_wr_en_out  = 1'b0;
    load_fault_out = 1'b0;
    accept         = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      WB: begin
        rf_wr_en_out  = rf_en_q & rd_nonzero & ~flush_in;
        csr_wr_en_out = csr_en_q & ~flush_in;
      end
      LOAD_WAIT: begin
        stall_out    = 1'b1;
        rf_wr_en_out = dmem_ack_in & rd_nonzero & ~flush_in;
        // An ack in the timeout cycle still completes the load.
        if (dmem_ack_in) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        stall_out      = 1'b1;
        load_fault_out = ~flush_in;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = valid_in & ~stall_out & ~flush_in;

    // IDLE and WB both accept; WB allows back-to-back issue.
    if ((state_q == IDLE) || (state_q == WB)) begin
      if (accept) begin
        state_d = is_load_in ? LOAD_WAIT : WB;
      end else begin
        state_d = IDLE;
      end
    end

    if (flush_in) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q  <= IDLE;
      sel_q    <= WB_ALU;
      rd_q     <= 5'd0;
      rf_en_q  <= 1'b0;
      csr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Captured fields hold their value when nothing is accepted.
      if (accept) begin
        sel_q    <= wb_mux_sel_in;
        rd_q     <= rd_addr_in;
        rf_en_q  <= rf_wr_en_in;
        csr_en_q <= csr_wr_en_in;
      end
    end
  end

  assign wb_mux_sel_reg_out = sel_q;
  assign rd_addr_reg_out    = rd_q;

endmodule

// File: tb/tb_msrv_32_wb_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_msrv_32_wb_ctrl_unit
// Directed scenarios with literal expectations, followed by randomized
// traffic. A per-cycle checker compares every output against a model that
// tracks "the instruction currently occupying stage 3" as a record.
// ---------------------------------------------------------------------------
module tb_msrv_32_wb_ctrl_unit;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [4:0] rd = 5'd0;
  logic       rf_en = 1'b0;
  logic       csr_en = 1'b0;
  logic       is_load = 1'b0;
  logic       ack = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] sel_out;
  logic [4:0] rd_out;
  logic       rf_wr, csr_wr, stall, fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msrv_32_wb_ctrl_unit #(.LOAD_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .valid_in              (valid),
    .wb_mux_sel_in         (sel),
    .rd_addr_in            (rd),
    .rf_wr_en_in           (rf_en),
    .csr_wr_en_in          (csr_en),
    .is_load_in            (is_load),
    .dmem_ack_in           (ack),
    .flush_in              (flush),
    .wb_mux_sel_reg_out    (sel_out),
    .rd_addr_reg_out       (rd_out),
    .rf_wr_en_out          (rf_wr),
    .csr_wr_en_out         (csr_wr),
    .stall_out             (stall),
    .load_fault_out        (fault)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] r,
                       input logic rf, input logic cs, input logic ld,
                       input logic a, input logic f);
    valid = v; sel = s; rd = r; rf_en = rf; csr_en = cs; is_load = ld;
    ack = a; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- behavioural model ----------------
  // One record describes the instruction sitting in stage 3, if any.
  typedef struct {
    bit         active;
    bit         is_load;
    bit         faulted;
    int         waited;
    logic [4:0] rd;
    bit         rf;
    bit         csr;
  } slot_t;

  slot_t      s;
  logic [2:0] m_sel;
  logic [4:0] m_rd;

  initial begin
    s = '{default: 0};
    m_sel = 3'd0;
    m_rd = 5'd0;
  end

  always @(negedge clk) begin
    bit e_stall, e_rf, e_csr, e_fault, acc;
    if (!rst_n) begin
      s = '{default: 0};
      m_sel = 3'd0;
      m_rd = 5'd0;
      chk("rst_stall", int'(stall), 0);
      chk("rst_rf_wr", int'(rf_wr), 0);
      chk("rst_csr_wr", int'(csr_wr), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_sel", int'(sel_out), 0);
      chk("rst_rd", int'(rd_out), 0);
    end else begin
      e_stall = s.active && s.is_load;
      e_fault = s.active && s.faulted && !flush;
      if (!s.active || flush) begin
        e_rf = 0;
        e_csr = 0;
      end else if (s.is_load) begin
        e_rf = !s.faulted && ack && (s.rd != 0);
        e_csr = 0;
      end else begin
        e_rf = s.rf && (s.rd != 0);
        e_csr = s.csr;
      end
      chk("m_stall", int'(stall), int'(e_stall));
      chk("m_rf_wr", int'(rf_wr), int'(e_rf));
      chk("m_csr_wr", int'(csr_wr), int'(e_csr));
      chk("m_fault", int'(fault), int'(e_fault));
      chk("m_sel", int'(sel_out), int'(m_sel));
      chk("m_rd", int'(rd_out), int'(m_rd));

      // Advance to what the next clock edge produces.
      acc = valid && !e_stall && !flush;
      if (flush) begin
        s.active = 0;
      end else if (acc) begin
        s.active = 1; s.is_load = is_load; s.faulted = 0; s.waited = 0;
        s.rd = rd; s.rf = rf_en; s.csr = csr_en;
        m_sel = sel; m_rd = rd;
      end else if (s.active) begin
        if (!s.is_load || s.faulted || ack) s.active = 0;
        else if (s.waited == TIMEOUT - 1) s.faulted = 1;
        else s.waited++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int stalled;
    int n;
    idle();
    repeat (3) cyc();
    chk("reset_sel", int'(sel_out), 0);
    chk("reset_stall", int'(stall), 0);
    rst_n = 1'b1;

    // 1: ALU op, strobe one cycle after accept
    cyc(); drive(1, 3'b000, 5'd5, 1, 0, 0, 0, 0);
    cyc(); idle(); #1;
    chk("t1_rf_wr", int'(rf_wr), 1);
    chk("t1_sel", int'(sel_out), 0);
    chk("t1_rd", int'(rd_out), 5);
    cyc();
    chk("t1_rf_wr_once", int'(rf_wr), 0);
    $display("test1 alu op done");

    // 2: load, ack in third stall cycle
    drive(1, 3'b001, 5'd7, 1, 0, 1, 0, 0);
    cyc(); idle(); #1;
    chk("t2_stall1", int'(stall), 1);
    chk("t2_no_wr1", int'(rf_wr), 0);
    cyc();
    chk("t2_stall2", int'(stall), 1);
    cyc(); ack = 1; #1;
    chk("t2_stall3", int'(stall), 1);
    chk("t2_rf_wr", int'(rf_wr), 1);
    chk("t2_sel", int'(sel_out), 1);
    chk("t2_rd", int'(rd_out), 7);
    cyc(); ack = 0; #1;
    chk("t2_stall_drop", int'(stall), 0);
    chk("t2_no_wr2", int'(rf_wr), 0);
    $display("test2 load with ack done");

    // 3: load without ack -> timeout fault
    drive(1, 3'b001, 5'd9, 1, 0, 1, 0, 0);
    cyc(); idle(); #1;
    stalled = 0; n = 0;
    while (n < 40 && !fault) begin
      if (stall) stalled++;
      cyc(); n++;
    end
    chk("t3_wait_cycles", stalled, TIMEOUT);
    chk("t3_fault", int'(fault), 1);
    chk("t3_fault_stall", int'(stall), 1);
    chk("t3_fault_no_wr", int'(rf_wr), 0);
    cyc();
    chk("t3_fault_once", int'(fault), 0);
    chk("t3_idle_stall", int'(stall), 0);
    $display("test3 load timeout done");

    // 4: back-to-back ALU, CSR, pc+4
    drive(1, 3'b000, 5'd1, 1, 0, 0, 0, 0);
    cyc(); drive(1, 3'b100, 5'd2, 1, 1, 0, 0, 0); #1;
    chk("t4_a_rf", int'(rf_wr), 1);
    chk("t4_a_rd", int'(rd_out), 1);
    chk("t4_a_stall", int'(stall), 0);
    cyc(); drive(1, 3'b101, 5'd3, 1, 0, 0, 0, 0); #1;
    chk("t4_b_csr", int'(csr_wr), 1);
    chk("t4_b_sel", int'(sel_out), 4);
    chk("t4_b_rd", int'(rd_out), 2);
    chk("t4_b_stall", int'(stall), 0);
    cyc(); idle(); #1;
    chk("t4_c_rf", int'(rf_wr), 1);
    chk("t4_c_csr", int'(csr_wr), 0);
    chk("t4_c_sel", int'(sel_out), 5);
    chk("t4_c_rd", int'(rd_out), 3);
    $display("test4 back-to-back done");

    // 5: flush in WB, flush mid load with ack, rd=x0
    cyc(); drive(1, 3'b000, 5'd4, 1, 1, 0, 0, 0);
    cyc(); idle(); flush = 1; #1;
    chk("t5_wb_flush_rf", int'(rf_wr), 0);
    chk("t5_wb_flush_csr", int'(csr_wr), 0);
    cyc(); flush = 0; #1;
    chk("t5_wb_flush_stall", int'(stall), 0);
    drive(1, 3'b001, 5'd6, 1, 0, 1, 0, 0);
    cyc(); idle();
    cyc(); ack = 1; flush = 1; #1;
    chk("t5_ld_flush_rf", int'(rf_wr), 0);
    cyc(); idle(); #1;
    chk("t5_ld_flush_stall", int'(stall), 0);
    drive(1, 3'b000, 5'd0, 1, 1, 0, 0, 0);
    cyc(); idle(); #1;
    chk("t5_x0_rf", int'(rf_wr), 0);
    chk("t5_x0_csr", int'(csr_wr), 1);
    $display("test5 flush and x0 done");

    // 6: asynchronous reset during LOAD_WAIT
    cyc(); drive(1, 3'b001, 5'd8, 1, 0, 1, 0, 0);
    cyc(); idle(); #1;
    chk("t6_pre_stall", int'(stall), 1);
    #1; rst_n = 0; #1;
    chk("t6_async_stall", int'(stall), 0);
    chk("t6_async_rd", int'(rd_out), 0);
    chk("t6_async_sel", int'(sel_out), 0);
    cyc(); rst_n = 1; ack = 1; #1;
    chk("t6_release_rf", int'(rf_wr), 0);
    chk("t6_release_stall", int'(stall), 0);
    cyc(); idle();
    $display("test6 async reset done");

    // Randomized traffic; every third block withholds acks to force timeouts.
    for (int i = 0; i < 3000; i++) begin
      logic ld;
      cyc();
      ld = ($urandom % 4) == 0;
      valid   = ($urandom % 4) != 0;
      is_load = ld;
      sel     = ld ? 3'b001 : 3'($urandom_range(0, 5));
      rd      = 5'($urandom);
      rf_en   = 1'($urandom);
      csr_en  = ($urandom % 3) == 0;
      ack     = (((i / 300) % 3) == 2) ? 1'b0 : (($urandom % 5) == 0);
      flush   = ($urandom % 25) == 0;
    end
    cyc(); idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
